// File: rtl/demux_8_loader.sv
// Registered 1-to-8 operand distributor: each accepted word lands in the slot picked by an
// auto-advancing (presettable) write pointer, with per-slot valid flags and a full state.
module demux_8_loader #(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [2:0]       addr,
  input  logic             addr_load,
  input  logic             clr,
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] Out2,
  output logic [WIDTH-1:0] Out3,
  output logic [WIDTH-1:0] Out4,
  output logic [WIDTH-1:0] Out5,
  output logic [WIDTH-1:0] Out6,
  output logic [WIDTH-1:0] Out7,
  output logic [WIDTH-1:0] Out8,
  output logic [7:0]       out_vld,
  output logic [7:0]       upd,
  output logic [2:0]       ptr,
  output logic             full
);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q [8];
  logic [7:0]       vld_q, vld_d;
  logic [7:0]       upd_q, upd_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       wsel;
  logic             accept;

  // A preset in the same cycle as an accept redirects that very word.
  assign wsel      = addr_load ? addr : ptr_q;
  assign din_ready = rst_n & ~clr & ~((state_q == FULL) & ~WRAP);
  assign accept    = din_valid & din_ready;

  always_comb begin
    vld_d   = vld_q;
    upd_d   = '0;
    ptr_d   = ptr_q;
    state_d = state_q;
    if (clr) begin
      vld_d   = '0;
      ptr_d   = '0;
      state_d = EMPTY;
    end else begin
      if (accept) begin
        vld_d[wsel] = 1'b1;
        upd_d       = 8'b1 << wsel;
        ptr_d       = wsel + 3'd1;
      end else if (addr_load) begin
        ptr_d = addr;
      end
      case (state_q)
        EMPTY:   if (accept) state_d = FILLING;
        FILLING: if (&vld_d) state_d = FULL;
        FULL:    state_d = FULL;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      vld_q   <= '0;
      upd_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      upd_q   <= upd_d;
      ptr_q   <= ptr_d;
    end
  end

  // Slot registers keep their contents across clr; only reset zeroes them.
  for (genvar gi = 0; gi < 8; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (!rst_n)
        data_q[gi] <= '0;
      else if (accept && (wsel == 3'(gi)))
        data_q[gi] <= din;
    end
  end

  assign Out1    = data_q[0];
  assign Out2    = data_q[1];
  assign Out3    = data_q[2];
  assign Out4    = data_q[3];
  assign Out5    = data_q[4];
  assign Out6    = data_q[5];
  assign Out7    = data_q[6];
  assign Out8    = data_q[7];
  assign out_vld = vld_q;
  assign upd     = upd_q;
  assign ptr     = ptr_q;
  assign full    = (state_q == FULL);

endmodule

// File: tb/tb_demux_8_loader.sv
// Drives a WRAP=0 and a WRAP=1 instance with identical stimulus and checks both against
// a slot-level reference model, directed steps first, then random traffic.
module tb_demux_8_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, din_valid, addr_load, clr;
  logic [7:0] din;
  logic [2:0] addr;

  logic [7:0] q0 [8];
  logic [7:0] q1 [8];
  logic       rdy  [2];
  logic [7:0] vld  [2];
  logic [7:0] upd  [2];
  logic [2:0] ptr  [2];
  logic       full [2];

  demux_8_loader #(.WIDTH(8), .WRAP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy[0]),
    .addr(addr), .addr_load(addr_load), .clr(clr),
    .Out1(q0[0]), .Out2(q0[1]), .Out3(q0[2]), .Out4(q0[3]),
    .Out5(q0[4]), .Out6(q0[5]), .Out7(q0[6]), .Out8(q0[7]),
    .out_vld(vld[0]), .upd(upd[0]), .ptr(ptr[0]), .full(full[0])
  );

  demux_8_loader #(.WIDTH(8), .WRAP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(rdy[1]),
    .addr(addr), .addr_load(addr_load), .clr(clr),
    .Out1(q1[0]), .Out2(q1[1]), .Out3(q1[2]), .Out4(q1[3]),
    .Out5(q1[4]), .Out6(q1[5]), .Out7(q1[6]), .Out8(q1[7]),
    .out_vld(vld[1]), .upd(upd[1]), .ptr(ptr[1]), .full(full[1])
  );

  // Reference model: slot contents, set of loaded slots, last-written slot, pointer.
  logic [7:0] m_data [2][8];
  logic [7:0] m_vld  [2];
  logic [7:0] m_upd  [2];
  int         m_ptr  [2];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dut_data(input int k);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = (k == 0) ? q0[i] : q1[i];
    return r;
  endfunction

  function automatic logic [63:0] model_data(input int k);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = m_data[k][i];
    return r;
  endfunction

  // Instance 1 is the wrapping one; a non-wrapping instance refuses words once all 8 are loaded.
  function automatic logic model_ready(input int k);
    return rst_n && !clr && !((m_vld[k] == 8'hFF) && (k == 0));
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic acc;
      int   slot;
      acc  = din_valid && model_ready(k);
      slot = addr_load ? int'(addr) : m_ptr[k];
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) m_data[k][i] = 8'h00;
        m_vld[k] = 8'h00; m_upd[k] = 8'h00; m_ptr[k] = 0;
      end else if (clr) begin
        m_vld[k] = 8'h00; m_upd[k] = 8'h00; m_ptr[k] = 0;
      end else if (acc) begin
        m_data[k][slot] = din;
        m_vld[k][slot]  = 1'b1;
        m_upd[k]        = 8'h00;
        m_upd[k][slot]  = 1'b1;
        m_ptr[k]        = (slot + 1) % 8;
      end else begin
        m_upd[k] = 8'h00;
        if (addr_load) m_ptr[k] = int'(addr);
      end
    end
  endtask

  task automatic step(input logic r, input logic c, input logic v, input logic [7:0] d,
                      input logic ld, input logic [2:0] a, input string label);
    rst_n = r; clr = c; din_valid = v; din = d; addr_load = ld; addr = a;
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("%s dut%0d din_ready", label, k), 64'(rdy[k]), 64'(model_ready(k)));
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s dut%0d data", label, k), dut_data(k), model_data(k));
      check($sformatf("%s dut%0d out_vld", label, k), 64'(vld[k]), 64'(m_vld[k]));
      check($sformatf("%s dut%0d upd", label, k), 64'(upd[k]), 64'(m_upd[k]));
      check($sformatf("%s dut%0d ptr", label, k), 64'(ptr[k]), 64'(m_ptr[k]));
      check($sformatf("%s dut%0d full", label, k), 64'(full[k]), 64'(m_vld[k] == 8'hFF));
    end
    if (label != "")
      $display("[%0t] %s: vld=%h/%h upd=%h/%h ptr=%0d/%0d full=%0b/%0b", $time, label,
               vld[0], vld[1], upd[0], upd[1], ptr[0], ptr[1], full[0], full[1]);
  endtask

  initial begin
    logic [7:0] w;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_data[k][i] = 8'h00;
      m_vld[k] = 8'h00; m_upd[k] = 8'h00; m_ptr[k] = 0;
    end

    step(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 3'd0, "reset0");
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, "reset1");

    for (int i = 1; i <= 8; i++) begin
      w = 8'(i * 8'h11);
      step(1'b1, 1'b0, 1'b1, w, 1'b0, 3'd0, $sformatf("fill%0d", i));
    end

    step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 3'd0, "full_push");
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, "idle_full");
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, "clr");

    step(1'b1, 1'b0, 1'b1, 8'h5C, 1'b1, 3'd5, "preset_accept");
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, "preset_only");
    step(1'b1, 1'b0, 1'b1, 8'h21, 1'b0, 3'd0, "acc_a");
    step(1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 3'd5, "overwrite_valid");
    step(1'b1, 1'b0, 1'b1, 8'h99, 1'b1, 3'd7, "wrap_ptr");
    step(1'b1, 1'b1, 1'b1, 8'h42, 1'b0, 3'd0, "clr_with_valid");
    step(1'b1, 1'b0, 1'b1, 8'h31, 1'b0, 3'd0, "acc_b");
    step(1'b0, 1'b0, 1'b1, 8'h32, 1'b0, 3'd0, "reset_mid");
    step(1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 3'd0, "first_after_reset");

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(99, 0) >= 2, $urandom_range(99, 0) < 5, $urandom_range(99, 0) < 75,
           8'($urandom), $urandom_range(99, 0) < 15, 3'($urandom), "");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
